// File: rtl/load_store_unit.sv
// load_store_unit: byte/halfword/word loads and stores over a word memory, with read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int N = 32,
  parameter int A = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [2:0]   req_funct3,
  input  logic [A-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         mem_we,
  output logic [A-1:0] mem_raddr,
  output logic [A-1:0] mem_waddr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, nxt;
  logic we_q, bad;
  logic [2:0] f3_q;
  logic [1:0] lane_q;
  logic [N-1:0] wdata_q, sh, ld, mask, ins, merged;
  always_comb begin
    bad = (req_we ? req_funct3 > 3'd2 : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11)) ||
          (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
          (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    sh = mem_rdata >> {lane_q, 3'b000};
    ld = f3_q[1] ? mem_rdata :
         f3_q[0] ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} : {{24{~f3_q[2] & sh[7]}}, sh[7:0]};
    mask = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {lane_q, 3'b000};
    ins = f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    merged = f3_q[1] ? wdata_q : (mem_rdata & ~mask) | (ins & mask);
    nxt = state == IDLE  ? (req_valid ? (bad ? RESP : READ) : IDLE) :
          state == READ  ? (we_q ? WRITE : RESP) :
          state == WRITE ? RESP : (rsp_ready ? IDLE : RESP);
  end
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  // gated by rst so a write aborted by reset never reaches memory
  assign mem_we = state == WRITE && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      we_q <= 1'b0;
      f3_q <= '0;
      lane_q <= '0;
      wdata_q <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        we_q <= req_we;
        f3_q <= req_funct3;
        lane_q <= req_addr[1:0];
        wdata_q <= req_wdata;
        rsp_err <= bad;
        rsp_rdata <= '0;
        if (!bad) mem_raddr <= {2'b00, req_addr[A-1:2]};
      end
      if (state == READ) begin
        rsp_rdata <= we_q ? '0 : ld;
        if (we_q) begin
          mem_waddr <= mem_raddr;
          mem_wdata <= merged;
        end
      end
    end
  end
endmodule
